// File: rtl/scrambler_arbiter.sv
// Packet-granular round-robin arbiter sharing one scrambler between N AXI-Stream sources.
// Loads the winner's seed into the scrambler, then passes the packet through tagged with its index.
module scrambler_arbiter #(
  parameter int unsigned        N            = 4,
  parameter int unsigned        WIDTH        = 24,
  parameter int unsigned        SEED_W       = 7,
  parameter logic [SEED_W-1:0]  DEFAULT_SEED = SEED_W'(7'b1011101),
  parameter int unsigned        IDX_W        = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [N*WIDTH-1:0]    s_axis_tdata,
  input  logic [N-1:0]          s_axis_tvalid,
  output logic [N-1:0]          s_axis_tready,
  input  logic [N-1:0]          s_axis_tlast,
  input  logic [N*SEED_W-1:0]   s_seed,
  output logic [WIDTH-1:0]      m_axis_tdata,
  output logic [3:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  scr_load,
  output logic [SEED_W-1:0]     scr_seed,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PASS = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick;
  logic [IDX_W-1:0]  cand;
  logic              found;
  logic              win;
  logic [SEED_W-1:0] picked_seed;
  logic [SEED_W-1:0] load_seed;
  logic              src_valid;
  logic              src_last;
  logic              beat_done;

  logic [WIDTH-1:0]  src_data [N];
  logic [SEED_W-1:0] src_seed [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign src_data[k] = s_axis_tdata[k*WIDTH +: WIDTH];
    assign src_seed[k] = s_seed[k*SEED_W +: SEED_W];
  end

  // Round-robin scan: first valid source at or after rr_ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % N);
      if (!found && s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // An all-zero seed would lock the scrambler LFSR, so substitute the default
  assign picked_seed = src_seed[pick];
  assign load_seed   = (picked_seed == '0) ? DEFAULT_SEED : picked_seed;
  assign win         = (state == IDLE) && found;

  assign src_valid = s_axis_tvalid[grant];
  assign src_last  = s_axis_tlast[grant];
  assign beat_done = (state == PASS) && src_valid && m_axis_tready && src_last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = PASS;
      PASS:    if (beat_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      scr_load <= 1'b0;
      scr_seed <= DEFAULT_SEED;
    end else begin
      state    <= state_nxt;
      scr_load <= win;
      if (win) begin
        grant    <= pick;
        scr_seed <= load_seed;
      end
      if (beat_done) begin
        rr_ptr <= (grant == IDX_W'(N - 1)) ? '0 : grant + IDX_W'(1);
      end
    end
  end

  // Unregistered pass-through of the granted source while in PASS
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    if (state == PASS) begin
      m_axis_tdata         = src_data[grant];
      m_axis_tvalid        = src_valid;
      m_axis_tlast         = src_last;
      m_axis_tuser         = 4'(grant);
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_scrambler_arbiter.sv
// Bench for scrambler_arbiter: per-source packet queues, expected-beat and expected-seed scoreboards,
// a downstream scrambler model, a table of single-packet vectors and hand-written multi-packet sequences.
module tb_scrambler_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 24;
  localparam int unsigned SW = 7;
  localparam logic [SW-1:0] DEF_SEED = 7'b1011101;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N*W-1:0]    s_axis_tdata;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [N-1:0]      s_axis_tlast;
  logic [N*SW-1:0]   s_seed;
  logic [W-1:0]      m_axis_tdata;
  logic [3:0]        m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              scr_load;
  logic [SW-1:0]     scr_seed;
  logic              busy;

  always #5 aclk = ~aclk;

  scrambler_arbiter #(
    .N(N), .WIDTH(W), .SEED_W(SW), .DEFAULT_SEED(DEF_SEED), .IDX_W(2)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_seed(s_seed),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .scr_load(scr_load), .scr_seed(scr_seed), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           hold;
  } beat_t;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   user;
    logic         last;
  } exp_t;

  typedef struct {
    int           src;
    logic [SW-1:0] seed;
    int           nbeats;
    logic [SW-1:0] exp_seed;
  } vec_t;

  beat_t         srcq [N][$];
  exp_t          sb[$];
  logic [SW-1:0] seedq[$];
  logic          rdy_pat[$];
  int            load_cycs[$];
  int            beat_cycs[$];
  int            last_cycs[$];
  logic [W-1:0]  first_words[$];
  logic [N-1:0]  hs;
  logic [SW-1:0] lfsr;
  logic          first_pending;
  logic          load_seen;
  int            cyc;
  int            n_pass;
  int            n_total;
  vec_t          tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Downstream additive scrambler, x^7 + x^6 + 1, LSB first
  function automatic logic [SW+W-1:0] scr_step(input logic [SW-1:0] s_in, input logic [W-1:0] d);
    logic [SW-1:0] s;
    logic [W-1:0]  o;
    logic          fb;
    s = s_in;
    o = '0;
    for (int i = 0; i < W; i++) begin
      fb   = s[6] ^ s[5];
      o[i] = d[i] ^ fb;
      s    = {s[5:0], fb};
    end
    return {s, o};
  endfunction

  task automatic monitor();
    exp_t e;
    logic [SW+W-1:0] r;
    hs = s_axis_tvalid & s_axis_tready;
    if (s_axis_tready != '0) begin
      chk("ready_onehot", 32'($countones(s_axis_tready)), 1);
      chk("ready_follows_m", 32'(m_axis_tready), 1);
      if (sb.size() != 0) chk("ready_src", 32'(s_axis_tready), 32'(1) << sb[0].user);
    end
    if (scr_load) begin
      chk("load_busy", 32'(busy), 1);
      chk("load_no_tvalid", 32'(m_axis_tvalid), 0);
      if (seedq.size() == 0) chk("unexpected_load", 32'(seedq.size()), 1);
      else chk("seed", 32'(scr_seed), 32'(seedq.pop_front()));
      lfsr = scr_seed;
      first_pending = 1'b1;
      load_seen = 1'b1;
      load_cycs.push_back(cyc);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) chk("unexpected_beat", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("beat_data", 32'(m_axis_tdata), 32'(e.data));
        chk("beat_user", 32'(m_axis_tuser), 32'(e.user));
        chk("beat_last", 32'(m_axis_tlast), 32'(e.last));
      end
      chk("beat_after_load", 32'(load_seen), 1);
      chk("beat_busy", 32'(busy), 1);
      r = scr_step(lfsr, m_axis_tdata);
      lfsr = r[SW+W-1:W];
      if (first_pending) begin
        first_words.push_back(r[W-1:0]);
        first_pending = 1'b0;
      end
      beat_cycs.push_back(cyc);
      if (m_axis_tlast) begin
        load_seen = 1'b0;
        last_cycs.push_back(cyc);
      end
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < N; k++) begin
      s_axis_tvalid[k] = 1'b0;
      s_axis_tlast[k]  = 1'b0;
      if (srcq[k].size() != 0) begin
        b = srcq[k][0];
        if (b.hold > 0) begin
          b.hold--;
          srcq[k][0] = b;
        end else begin
          s_axis_tvalid[k]          = 1'b1;
          s_axis_tlast[k]           = b.last;
          s_axis_tdata[k*W +: W]    = b.data;
        end
      end
    end
    m_axis_tready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
  endtask

  // Sample at the falling edge, then update sources just after the rising edge
  task automatic tick();
    @(negedge aclk);
    cyc++;
    monitor();
    @(posedge aclk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) void'(srcq[k].pop_front());
    drive();
  endtask

  task automatic set_seed(input int k, input logic [SW-1:0] v);
    s_seed[k*SW +: SW] = v;
  endtask

  task automatic send_pkt(input int k, input int nb, input int pid, input int hold_at, input logic zero);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nb; i++) begin
      b.data = zero ? '0 : W'((k << 20) | (pid << 8) | i);
      b.last = (i == nb - 1);
      b.hold = (i == hold_at) ? 2 : 0;
      srcq[k].push_back(b);
      e.data = b.data;
      e.user = 4'(k);
      e.last = b.last;
      sb.push_back(e);
    end
  endtask

  task automatic run_drain(input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || seedq.size() != 0); i++) tick();
    chk("drain", 32'(sb.size() + seedq.size()), 0);
    tick();
    tick();
  endtask

  task automatic clear_logs();
    load_cycs.delete();
    beat_cycs.delete();
    last_cycs.delete();
    first_words.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW+W-1:0] r;
    n_pass = 0; n_total = 0; cyc = 0;
    hs = '0; lfsr = '0; first_pending = 1'b0; load_seen = 1'b0;
    tbl[0] = '{src: 1, seed: 7'h7f, nbeats: 3, exp_seed: 7'h7f};
    tbl[1] = '{src: 2, seed: 7'h00, nbeats: 2, exp_seed: DEF_SEED};
    tbl[2] = '{src: 3, seed: 7'h12, nbeats: 1, exp_seed: 7'h12};
    tbl[3] = '{src: 0, seed: 7'h01, nbeats: 2, exp_seed: 7'h01};
    tbl[4] = '{src: 3, seed: 7'h00, nbeats: 3, exp_seed: DEF_SEED};

    areset = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    s_seed = '0; m_axis_tready = 1'b1;
    repeat (3) tick();
    areset = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(scr_load), 0);
    chk("rst_seed", 32'(scr_seed), 32'(DEF_SEED));
    chk("rst_s_ready", 32'(s_axis_tready), 0);
    chk("rst_m_valid", 32'(m_axis_tvalid), 0);
    chk("rst_m_last", 32'(m_axis_tlast), 0);
    chk("rst_m_user", 32'(m_axis_tuser), 0);
    chk("rst_m_data", 32'(m_axis_tdata), 0);

    // Single source, exact timing, and seed change after grant is ignored
    clear_logs();
    set_seed(1, 7'h7f);
    send_pkt(1, 3, 1, -1, 1'b0);
    seedq.push_back(7'h7f);
    for (int i = 0; i < 20 && load_cycs.size() == 0; i++) tick();
    chk("load_timeout", 32'(load_cycs.size()), 1);
    set_seed(1, 7'h33);
    run_drain(30);
    chk("seed_held", 32'(scr_seed), 32'(7'h7f));
    chk("single_nbeats", 32'(beat_cycs.size()), 3);
    if (beat_cycs.size() == 3 && load_cycs.size() == 1)
      for (int b = 0; b < 3; b++) chk("single_beat_cycle", 32'(beat_cycs[b]), 32'(load_cycs[0] + 1 + b));
    chk("idle_busy", 32'(busy), 0);

    // Table of single-packet vectors
    for (int v = 0; v < 5; v++) begin
      set_seed(tbl[v].src, tbl[v].seed);
      send_pkt(tbl[v].src, tbl[v].nbeats, 16 + v, -1, 1'b0);
      seedq.push_back(tbl[v].exp_seed);
      run_drain(40);
    end

    // Round robin with all sources pending: order 0,1,2,3,0 with IDLE+LOAD gaps
    clear_logs();
    for (int k = 0; k < N; k++) set_seed(k, SW'(7'h10 + k));
    for (int p = 0; p < 5; p++) begin
      send_pkt(p % N, 2, 32 + p, -1, 1'b0);
      seedq.push_back(SW'(7'h10 + (p % N)));
    end
    run_drain(100);
    chk("rr_loads", 32'(load_cycs.size()), 5);
    if (load_cycs.size() == 5 && last_cycs.size() == 5)
      for (int i = 1; i < 5; i++) chk("rr_gap", 32'(load_cycs[i] - last_cycs[i-1]), 2);

    // Backpressure on src3 with src0 waiting; zero data exposes the scrambler sequence
    clear_logs();
    set_seed(3, 7'h00);
    set_seed(0, 7'h21);
    send_pkt(3, 4, 48, -1, 1'b1);
    seedq.push_back(DEF_SEED);
    tick();
    tick();
    send_pkt(0, 2, 49, -1, 1'b0);
    seedq.push_back(7'h21);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    run_drain(60);
    r = scr_step(DEF_SEED, '0);
    chk("bp_first_words", 32'(first_words.size()), 2);
    if (first_words.size() != 0) chk("bp_scr_word0", 32'(first_words[0]), 32'(r[W-1:0]));

    // Valid gap on src0 mid-packet while src1 waits
    set_seed(0, 7'h0a);
    set_seed(1, 7'h0b);
    send_pkt(0, 4, 64, 2, 1'b0);
    seedq.push_back(7'h0a);
    tick();
    tick();
    send_pkt(1, 2, 65, -1, 1'b0);
    seedq.push_back(7'h0b);
    run_drain(60);

    // Reset mid-PASS: outputs drop at once and priority restarts at source 0
    clear_logs();
    send_pkt(1, 4, 80, -1, 1'b0);
    seedq.push_back(7'h0b);
    for (int i = 0; i < 20 && beat_cycs.size() == 0; i++) tick();
    chk("mid_beat_timeout", 32'(beat_cycs.size()), 1);
    #2;
    areset = 1'b1;
    #1;
    chk("arst_m_valid", 32'(m_axis_tvalid), 0);
    chk("arst_s_ready", 32'(s_axis_tready), 0);
    chk("arst_m_last", 32'(m_axis_tlast), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_seed", 32'(scr_seed), 32'(DEF_SEED));
    for (int k = 0; k < N; k++) srcq[k].delete();
    sb.delete();
    seedq.delete();
    rdy_pat.delete();
    load_seen = 1'b0;
    repeat (2) tick();
    areset = 1'b0;
    set_seed(2, 7'h2c);
    set_seed(0, 7'h0c);
    send_pkt(0, 2, 81, -1, 1'b0);
    seedq.push_back(7'h0c);
    send_pkt(2, 2, 82, -1, 1'b0);
    seedq.push_back(7'h2c);
    run_drain(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
